// File: rtl/ep01_truth_scanner.sv
// ep01_truth_scanner: drives all 16 {a,b,c,d} vectors into the ep01 block and captures f into a truth table.
// Reports the table, its popcount and a match flag against EXPECTED_TT.
module ep01_truth_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED_TT   = 16'h0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        f_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] table_o,
    output logic [4:0]  ones_count_o,
    output logic        pass_o
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);
    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [15:0] table_q;
    logic [15:0] table_d;
    logic [4:0]  ones_q;
    logic [4:0]  ones_d;
    logic        pass_q;
    logic        busy_q;
    logic        done_q;
    // Table as it will be after the current capture; popcount and pass are latched from it on the final capture.
    always_comb begin
        table_d = table_q;
        table_d[idx_q] = f_i;
        ones_d = '0;
        for (int i = 0; i < 16; i++) ones_d = ones_d + 5'(table_d[i]);
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        table_q <= '0;
                        ones_q  <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != LAST) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        table_q <= table_d;
                        cnt_q   <= '0;
                        if (idx_q != 4'd15) begin
                            idx_q <= idx_q + 4'd1;
                        end else begin
                            ones_q  <= ones_d;
                            pass_q  <= (table_d == EXPECTED_TT);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign {a_o, b_o, c_o, d_o} = idx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign table_o      = table_q;
    assign ones_count_o = ones_q;
    assign pass_o       = pass_q;
endmodule

// File: tb/tb_ep01_truth_scanner.sv
// tb_ep01_truth_scanner: directed bench for ep01_truth_scanner with stub ep01 blocks.
module tb_ep01_truth_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst1, start1, f1, a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] tt1;
    logic [4:0] ones1;
    logic rst3, start3, f3, a3, b3, c3, d3, busy3, done3, pass3;
    logic [15:0] tt3;
    logic [4:0] ones3;
    logic [1:0] mode;
    int checks = 0;
    int errors = 0;
    assign f1 = (mode == 2'd0) ? (a1 & b1) : (mode == 2'd1) ? (a1 ^ b1 ^ c1 ^ d1) : ~a1;
    assign f3 = d3;
    ep01_truth_scanner #(.SETTLE_CYCLES(1), .EXPECTED_TT(16'hF000)) u1 (
        .clock_i(clk), .reset_i(rst1), .start_i(start1), .f_i(f1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
        .table_o(tt1), .ones_count_o(ones1), .pass_o(pass1)
    );
    ep01_truth_scanner #(.SETTLE_CYCLES(3), .EXPECTED_TT(16'hAAAA)) u3 (
        .clock_i(clk), .reset_i(rst3), .start_i(start3), .f_i(f3),
        .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3), .busy_o(busy3), .done_o(done3),
        .table_o(tt3), .ones_count_o(ones3), .pass_o(pass3)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Pulses start, returns edges from the start edge up to and including the one that raises done.
    task automatic scan(input bit slow, output int lat);
        if (slow) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        lat = 1;
        while (!(slow ? done3 : done1) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask
    initial begin
        int lat;
        int pulses;
        int gap;
        mode = 2'd0;
        rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        chk("rst_table", 32'(tt1), 32'h0);
        chk("rst_ones", 32'(ones1), 32'h0);
        chk("rst_pass", 32'(pass1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_abcd", 32'({a1, b1, c1, d1}), 32'h0);
        chk("rst_table3", 32'(tt3), 32'h0);
        // f = a&b, walk vectors one per cycle
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("and_busy", 32'(busy1), 32'h1);
        chk("and_vec0", 32'({a1, b1, c1, d1}), 32'h0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("and_vec%0d", i), 32'({a1, b1, c1, d1}), 32'(i));
        end
        chk("and_done_early", 32'(done1), 32'h0);
        @(negedge clk);
        chk("and_done", 32'(done1), 32'h1);
        chk("and_busy_done", 32'(busy1), 32'h0);
        chk("and_table", 32'(tt1), 32'hF000);
        chk("and_ones", 32'(ones1), 32'd4);
        chk("and_pass", 32'(pass1), 32'h1);
        chk("and_abcd_hold", 32'({a1, b1, c1, d1}), 32'hF);
        @(negedge clk);
        chk("and_done_pulse", 32'(done1), 32'h0);
        @(negedge clk);
        chk("idle_table_hold", 32'(tt1), 32'hF000);
        chk("idle_pass_hold", 32'(pass1), 32'h1);
        // parity
        mode = 2'd1;
        scan(1'b0, lat);
        chk("par_lat", 32'(lat), 32'd17);
        chk("par_table", 32'(tt1), 32'h6996);
        chk("par_ones", 32'(ones1), 32'd8);
        chk("par_pass", 32'(pass1), 32'h0);
        repeat (2) @(negedge clk);
        // slow scanner, f = d
        scan(1'b1, lat);
        chk("slow_lat", 32'(lat), 32'd49);
        chk("slow_table", 32'(tt3), 32'hAAAA);
        chk("slow_ones", 32'(ones3), 32'd8);
        chk("slow_pass", 32'(pass3), 32'h1);
        // reset at vector 7
        mode = 2'd0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_vec7", 32'({a1, b1, c1, d1}), 32'h7);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("mid_abcd", 32'({a1, b1, c1, d1}), 32'h0);
        chk("mid_busy", 32'(busy1), 32'h0);
        chk("mid_table", 32'(tt1), 32'h0);
        chk("mid_ones", 32'(ones1), 32'h0);
        chk("mid_pass", 32'(pass1), 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1 || busy1) pulses++;
        end
        chk("mid_no_done", 32'(pulses), 32'd0);
        scan(1'b0, lat);
        chk("mid_rescan_lat", 32'(lat), 32'd17);
        chk("mid_rescan_table", 32'(tt1), 32'hF000);
        chk("mid_rescan_pass", 32'(pass1), 32'h1);
        repeat (2) @(negedge clk);
        // extra starts during SETTLE and DONE
        mode = 2'd1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 200) begin
            start1 = (lat == 5);
            @(negedge clk);
            lat++;
        end
        start1 = 1'b0;
        chk("ign_lat", 32'(lat), 32'd17);
        pulses = 1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done1 || busy1) pulses++;
            @(negedge clk);
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_table", 32'(tt1), 32'h6996);
        // start held high, f = ~a
        mode = 2'd2;
        start1 = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 32'(lat), 32'd17);
        chk("hold_table1", 32'(tt1), 32'h00FF);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 2) begin
                chk("hold_clear", 32'(tt1), 32'h0);
                chk("hold_busy2", 32'(busy1), 32'h1);
            end
        end while (!done1 && gap < 200);
        start1 = 1'b0;
        chk("hold_gap", 32'(gap), 32'd18);
        chk("hold_table2", 32'(tt1), 32'h00FF);
        chk("hold_ones", 32'(ones1), 32'd8);
        chk("hold_pass", 32'(pass1), 32'h0);
        repeat (3) @(negedge clk);
        chk("hold_stop", 32'(busy1), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
